alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_ctrl_pkg.sv | 26 ++
 rtl/alu_issue_ctrl_regfile_4x2.sv | 45 ++++
 rtl/alu_issue_ctrl.sv | 168 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and instruction field positions for the ALU issue controller.
package alu_ctrl_pkg;

  // Issue FSM states: waiting for work, driving the ALU, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // ALU operation select as carried in the instruction word.
  typedef logic [1:0] alu_op_t;

  // Instruction word layout: {control[1:0], rd[1:0], rs[1:0]}.
  localparam int INSTR_W        = 6;
  localparam int INSTR_CTRL_MSB = 5;
  localparam int INSTR_CTRL_LSB = 4;
  localparam int RD_MSB         = 3;
  localparam int RD_LSB         = 2;
  localparam int RS_MSB         = 1;
  localparam int RS_LSB         = 0;

  // Register index width.
  localparam int REG_AW = 2;

endpackage

// File: rtl/alu_issue_ctrl_regfile_4x2.sv
// Small register file: one synchronous write port, two asynchronous read
// ports, asynchronous active-low clear of every entry.
module regfile_4x2
  import alu_ctrl_pkg::*;
#(
  parameter int DW   = 2,
  parameter int NREG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DW-1:0]     rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DW-1:0]     rdata_b
);

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];

  // Next register contents: everything holds except the addressed entry on a write.
  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  // Register storage, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external combinational ALU: accepts one instruction
// at a time, presents operands for one cycle, captures the result, and writes
// it back to the register file when the consumer takes it.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DW   = 2,
  parameter int NREG = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               wr_en,
  input  logic [REG_AW-1:0]  wr_addr,
  input  logic [DW-1:0]      wr_data,
  output logic [DW-1:0]      alu_r0_rd,
  output logic [DW-1:0]      alu_rs,
  output logic [1:0]         alu_control,
  input  logic [DW:0]        alu_result,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DW:0]        res_data,
  output logic [REG_AW-1:0]  res_rd,
  output logic               carry
);

  state_t state_q, state_d;

  alu_op_t           ctrl_q, ctrl_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [DW-1:0]     op_a_q, op_a_d;
  logic [DW-1:0]     op_b_q, op_b_d;
  logic [DW:0]       res_data_q, res_data_d;
  logic [REG_AW-1:0] res_rd_q, res_rd_d;
  logic              carry_q, carry_d;

  logic              accept;
  logic              res_fire;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DW-1:0]     rf_wdata;
  logic [DW-1:0]     rf_rdata_a;
  logic [DW-1:0]     rf_rdata_b;

  assign accept   = instr_valid && instr_ready;
  assign res_fire = res_valid && res_ready;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: accept -> one execute cycle -> hold result until taken.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)   state_d = EXEC;
      EXEC:                  state_d = RESP;
      RESP:    if (res_fire) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // FSM outputs; operands follow the register file live in EXEC and hold otherwise.
  always_comb begin
    instr_ready = (state_q == IDLE);
    res_valid   = (state_q == RESP);
    alu_control = ctrl_q;
    alu_r0_rd   = op_a_q;
    alu_rs      = op_b_q;
    if (state_q == EXEC) begin
      alu_r0_rd = rf_rdata_a;
      alu_rs    = rf_rdata_b;
    end
  end

  // Datapath next values: field latch on accept, operand/result capture in EXEC, carry on retire.
  always_comb begin
    ctrl_d     = ctrl_q;
    rd_d       = rd_q;
    rs_d       = rs_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    res_data_d = res_data_q;
    res_rd_d   = res_rd_q;
    carry_d    = carry_q;
    if (accept) begin
      ctrl_d = instr[INSTR_CTRL_MSB:INSTR_CTRL_LSB];
      rd_d   = instr[RD_MSB:RD_LSB];
      rs_d   = instr[RS_MSB:RS_LSB];
    end
    if (state_q == EXEC) begin
      op_a_d     = rf_rdata_a;
      op_b_d     = rf_rdata_b;
      res_data_d = alu_result;
      res_rd_d   = rd_q;
    end
    if (res_fire) begin
      carry_d = res_data_q[DW];
    end
  end

  // Datapath registers; reset drops any in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= '0;
      rd_q       <= '0;
      rs_q       <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      res_data_q <= '0;
      res_rd_q   <= '0;
      carry_q    <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      rd_q       <= rd_d;
      rs_q       <= rs_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      res_data_q <= res_data_d;
      res_rd_q   <= res_rd_d;
      carry_q    <= carry_d;
    end
  end

  // Single write port shared by preload (IDLE only) and retire (RESP only);
  // the two can never coincide, and a preload lands on the same edge as an
  // accept so the EXEC cycle that follows already reads the new value.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = wr_addr;
    rf_wdata = wr_data;
    if (res_fire) begin
      rf_we    = 1'b1;
      rf_waddr = res_rd_q;
      rf_wdata = res_data_q[DW-1:0];
    end else if (wr_en && (state_q == IDLE)) begin
      rf_we = 1'b1;
    end
  end

  regfile_4x2 #(
    .DW   (DW),
    .NREG (NREG)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (rd_q),
    .rdata_a (rf_rdata_a),
    .raddr_b (rs_q),
    .rdata_b (rf_rdata_b)
  );

  assign res_data = res_data_q;
  assign res_rd   = res_rd_q;
  assign carry    = carry_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU and a
// scoreboard queue checked by an independent result monitor.
module tb_alu_issue_ctrl;

   localparam int DW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          instr_valid;
   logic          instr_ready;
   logic [5:0]    instr;
   logic          wr_en;
   logic [1:0]    wr_addr;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] alu_r0_rd;
   logic [DW-1:0] alu_rs;
   logic [1:0]    alu_control;
   logic [DW:0]   alu_result;
   logic          res_valid;
   logic          res_ready;
   logic [DW:0]   res_data;
   logic [1:0]    res_rd;
   logic          carry;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [4:0] sbQ [$];
   int accQ [$];

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // ALU model: 00 add, 01 subtract, 10 and, 11 add with carry-in.
   always_comb begin
      alu_result = '0;
      case (alu_control)
         2'b00: alu_result = {1'b0, alu_r0_rd} + {1'b0, alu_rs};
         2'b01: alu_result = {1'b0, alu_r0_rd} - {1'b0, alu_rs};
         2'b10: alu_result = {1'b0, alu_r0_rd & alu_rs};
         default: alu_result = {1'b0, alu_r0_rd} + {1'b0, alu_rs} + 3'd1;
      endcase
   end

   alu_issue_ctrl #(.DW(DW), .NREG(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .alu_r0_rd   (alu_r0_rd),
      .alu_rs      (alu_rs),
      .alu_control (alu_control),
      .alu_result  (alu_result),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_rd      (res_rd),
      .carry       (carry)
   );

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge, where inputs are driven.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Preload one register through the external write port.
   task automatic preload(input logic [1:0] addr, input logic [DW-1:0] data);
      wr_en   = 1'b1;
      wr_addr = addr;
      wr_data = data;
      tick();
      wr_en   = 1'b0;
   endtask

   // Issue one instruction and walk it through EXEC and RESP, optionally
   // stalling the consumer and poking the write port along the way.
   task automatic applyStimulus(input logic [5:0] ins, input logic [1:0] expA, input logic [1:0] expB,
                                input logic [2:0] expData, input int stall,
                                input logic wrAtAccept, input logic wrInFlight,
                                input logic [1:0] wAddr, input logic [1:0] wData);
      logic [1:0] ctl;
      ctl         = ins[5:4];
      instr       = ins;
      instr_valid = 1'b1;
      res_ready   = (stall == 0);
      wr_en       = wrAtAccept;
      wr_addr     = wAddr;
      wr_data     = wData;
      @(negedge clk);
      checkOutput("ready_before_accept", instr_ready, 1);
      sbQ.push_back({ins[3:2], expData});
      tick();
      instr_valid = 1'b0;
      wr_en       = wrInFlight;
      @(negedge clk);
      checkOutput("exec_control", alu_control, ctl);
      checkOutput("exec_op_rd", alu_r0_rd, expA);
      checkOutput("exec_op_rs", alu_rs, expB);
      checkOutput("exec_no_valid", res_valid, 0);
      checkOutput("exec_not_ready", instr_ready, 0);
      tick();
      @(negedge clk);
      checkOutput("resp_valid", res_valid, 1);
      checkOutput("resp_data", res_data, expData);
      checkOutput("resp_rd", res_rd, ins[3:2]);
      checkOutput("resp_not_ready", instr_ready, 0);
      if (stall > 0) begin
         for (int i = 1; i < stall; i++) begin
            tick();
            @(negedge clk);
            checkOutput("stall_valid", res_valid, 1);
            checkOutput("stall_data", res_data, expData);
            checkOutput("stall_rd", res_rd, ins[3:2]);
            checkOutput("stall_not_ready", instr_ready, 0);
         end
         tick();
         res_ready = 1'b1;
      end
      tick();
      wr_en = 1'b0;
      @(negedge clk);
      checkOutput("retire_idle_ready", instr_ready, 1);
      checkOutput("retire_valid_low", res_valid, 0);
      checkOutput("retire_carry", carry, expData[2]);
      tick();
   endtask

   // Result monitor: pops the scoreboard on every result handshake.
   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready) begin
         if (sbQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL sb_unexpected: got result %0d rd %0d with nothing expected", res_data, res_rd);
         end else begin
            logic [4:0] e;
            e = sbQ.pop_front();
            checkOutput("sb_res_data", res_data, e[2:0]);
            checkOutput("sb_res_rd", res_rd, e[4:3]);
         end
      end
   end

   // Accept recorder: notes the cycle of every instruction handshake.
   always @(negedge clk) begin
      if (rst_n && instr_valid && instr_ready) begin
         accQ.push_back(cyc);
      end
      cyc++;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios.
   initial begin
      int guard;
      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr       = '0;
      wr_en       = 1'b0;
      wr_addr     = '0;
      wr_data     = '0;
      res_ready   = 1'b1;
      #1;
      checkOutput("rst_res_valid", res_valid, 0);
      checkOutput("rst_res_data", res_data, 0);
      checkOutput("rst_res_rd", res_rd, 0);
      checkOutput("rst_alu_a", alu_r0_rd, 0);
      checkOutput("rst_alu_b", alu_rs, 0);
      checkOutput("rst_alu_ctl", alu_control, 0);
      checkOutput("rst_carry", carry, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      $display("[TB] idle with instr_valid low");
      instr = 6'b11_11_11;
      repeat (3) tick();
      @(negedge clk);
      checkOutput("idle_ready", instr_ready, 1);
      checkOutput("idle_no_valid", res_valid, 0);
      checkOutput("idle_ctl_unchanged", alu_control, 0);
      tick();

      $display("[TB] scenario 1: add r0,r1");
      preload(2'd0, 2'd3);
      preload(2'd1, 2'd3);
      applyStimulus(6'b00_00_01, 2'd3, 2'd3, 3'b110, 0, 1'b0, 1'b0, 2'd0, 2'd0);

      $display("[TB] scenario 2: stalled result");
      preload(2'd2, 2'd1);
      preload(2'd3, 2'd0);
      applyStimulus(6'b11_10_11, 2'd1, 2'd0, 3'b010, 5, 1'b0, 1'b0, 2'd0, 2'd0);

      $display("[TB] scenario 3: back-to-back");
      accQ.delete();
      res_ready   = 1'b1;
      sbQ.push_back({2'd3, 3'b010});
      instr       = 6'b00_11_10;
      instr_valid = 1'b1;
      guard = 0;
      while (accQ.size() < 1 && guard < 10) begin
         tick();
         guard++;
      end
      instr = 6'b00_00_11;
      sbQ.push_back({2'd0, 3'b100});
      guard = 0;
      while (accQ.size() < 2 && guard < 10) begin
         tick();
         guard++;
      end
      instr_valid = 1'b0;
      @(negedge clk);
      checkOutput("b2b_second_op_rd", alu_r0_rd, 2);
      checkOutput("b2b_second_op_rs", alu_rs, 2);
      checkOutput("b2b_accept_gap", (accQ.size() >= 2) ? (accQ[1] - accQ[0]) : 0, 3);
      tick();
      tick();
      @(negedge clk);
      checkOutput("b2b_carry", carry, 1);
      tick();

      $display("[TB] scenario 4: write port in flight and with accept");
      applyStimulus(6'b01_10_00, 2'd2, 2'd0, 3'b010, 0, 1'b0, 1'b1, 2'd1, 2'd2);
      applyStimulus(6'b01_01_11, 2'd3, 2'd2, 3'b001, 0, 1'b0, 1'b0, 2'd0, 2'd0);
      applyStimulus(6'b10_01_01, 2'd2, 2'd2, 3'b010, 0, 1'b1, 1'b0, 2'd1, 2'd2);
      applyStimulus(6'b00_01_01, 2'd2, 2'd2, 3'b100, 0, 1'b0, 1'b0, 2'd0, 2'd0);

      $display("[TB] scenario 5: reset during RESP");
      instr       = 6'b00_10_11;
      instr_valid = 1'b1;
      res_ready   = 1'b0;
      tick();
      instr_valid = 1'b0;
      @(negedge clk);
      checkOutput("pre_rst_op_rd", alu_r0_rd, 2);
      checkOutput("pre_rst_op_rs", alu_rs, 2);
      tick();
      @(negedge clk);
      checkOutput("pre_rst_valid", res_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_valid", res_valid, 0);
      checkOutput("mid_rst_data", res_data, 0);
      checkOutput("mid_rst_rd", res_rd, 0);
      checkOutput("mid_rst_alu_a", alu_r0_rd, 0);
      checkOutput("mid_rst_alu_b", alu_rs, 0);
      checkOutput("mid_rst_ctl", alu_control, 0);
      checkOutput("mid_rst_carry", carry, 0);
      checkOutput("mid_rst_ready", instr_ready, 1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      res_ready = 1'b1;
      applyStimulus(6'b00_10_11, 2'd0, 2'd0, 3'b000, 0, 1'b0, 1'b0, 2'd0, 2'd0);
      applyStimulus(6'b00_00_01, 2'd0, 2'd0, 3'b000, 0, 1'b0, 1'b0, 2'd0, 2'd0);

      repeat (3) tick();
      checkOutput("sb_drained", sbQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
